cgp_fitness_evaluator: RTL and testbench

//   Drives the primary inputs of an evolved CGP LUT fabric and reads back its outputs.

---
 rtl/cgp_pkg.sv | 9 +
 rtl/cgp_sync2.sv | 21 ++
 rtl/cgp_fitness_evaluator.sv | 103 ++++++++++
 tb/tb_cgp_fitness_evaluator.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cgp_pkg.sv
// cgp_pkg: shared defaults, FSM state type and score-width helper for the CGP fitness evaluator
package cgp_pkg;
  localparam int CGP_N_IN  = 4;
  localparam int CGP_N_OUT = 4;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} cgp_state_e;
  function automatic int cgp_score_w(input int n_in, input int n_out);
    return $clog2(n_out * (1 << n_in) + 1);
  endfunction
endpackage

// File: rtl/cgp_sync2.sv
// cgp_sync2: W-bit two-flop synchroniser for the asynchronous fabric outputs
module cgp_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1, r_s2;
  // two-stage capture of the fabric outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  assign o_q = r_s2;
endmodule

// File: rtl/cgp_fitness_evaluator.sv
// cgp_fitness_evaluator: sweeps every input vector of a CGP fabric and scores its outputs against a truth table
module cgp_fitness_evaluator
  import cgp_pkg::*;
#(
  parameter int N_IN          = CGP_N_IN,
  parameter int N_OUT         = CGP_N_OUT,
  parameter int SETTLE_CYCLES = 4,
  localparam int N_VEC  = 1 << N_IN,
  localparam int N_BITS = N_OUT * N_VEC,
  localparam int SW     = cgp_score_w(N_IN, N_OUT),
  localparam int CW     = $clog2(SETTLE_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [N_BITS-1:0] i_target,
  output logic [N_IN-1:0]   o_dut_in,
  input  logic [N_OUT-1:0]  i_dut_out,
  output logic              o_busy,
  output logic              o_done,
  output logic [SW-1:0]     o_score,
  output logic              o_perfect
);
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 3 to cover synchroniser latency");
  end
  localparam logic [SW-1:0] MAX_SCORE = SW'(N_BITS);
  cgp_state_e        r_state;
  logic [N_BITS-1:0] r_target;
  logic [N_IN-1:0]   r_vec;
  logic [CW-1:0]     r_cnt;
  logic [N_OUT-1:0]  w_sync, w_match;
  logic [SW-1:0]     w_pop;
  cgp_sync2 #(.W(N_OUT)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (i_dut_out),
    .o_q  (w_sync)
  );
  assign w_match = ~(w_sync ^ r_target[int'(r_vec) * N_OUT +: N_OUT]);
  // number of fabric outputs matching the target for the current vector
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < N_OUT; k++) w_pop = w_pop + SW'(w_match[k]);
  end
  // evaluation sequencer: drive a vector, let it settle, score it, advance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_target  <= '0;
      r_vec     <= '0;
      r_cnt     <= '0;
      o_dut_in  <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_score   <= '0;
      o_perfect <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_abort && r_state != IDLE) begin
        r_state   <= IDLE;
        o_busy    <= 1'b0;
        o_dut_in  <= '0;
        o_perfect <= 1'b0;
      end else
        case (r_state)
          IDLE:
            if (i_start && !i_abort) begin
              r_target  <= i_target;
              o_score   <= '0;
              o_perfect <= 1'b0;
              r_vec     <= '0;
              r_cnt     <= '0;
              o_dut_in  <= '0;
              o_busy    <= 1'b1;
              r_state   <= DRIVE;
            end
          DRIVE: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(SETTLE_CYCLES - 1)) r_state <= SAMPLE;
          end
          SAMPLE: begin
            o_score <= o_score + w_pop;
            r_cnt   <= '0;
            if (r_vec == N_IN'(N_VEC - 1)) r_state <= DONE;
            else begin
              r_vec    <= r_vec + 1'b1;
              o_dut_in <= r_vec + 1'b1;
              r_state  <= DRIVE;
            end
          end
          DONE: begin
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            o_perfect <= (o_score == MAX_SCORE);
            o_dut_in  <= '0;
            r_state   <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_cgp_fitness_evaluator.sv
// tb_cgp_fitness_evaluator: scoreboard bench with an identity fabric stub delayed by two cycles
module tb_cgp_fitness_evaluator;
  localparam logic [63:0] ID_T  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] INV_T = 64'h0123_4567_89AB_CDEF;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [63:0] target = '0;
  logic [3:0] dut_in, dut_out, f1 = '0, f2 = '0;
  logic busy, done, perfect;
  logic [6:0] score;
  int cyc = 0, checks = 0, failures = 0, n_done = 0, n_exp = 0, s = 0;
  typedef struct {int score; bit perfect; int cyc;} exp_t;
  exp_t sb[$];

  cgp_fitness_evaluator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (start),
    .i_abort  (abort),
    .i_target (target),
    .o_dut_in (dut_in),
    .i_dut_out(dut_out),
    .o_busy   (busy),
    .o_done   (done),
    .o_score  (score),
    .o_perfect(perfect)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    f1 <= dut_in;
    f2 <= f1;
  end
  assign dut_out = f2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) check("unexpected_done", done, 0);
      else begin
        e = sb.pop_front();
        check("score", score, e.score);
        check("perfect", perfect, e.perfect);
        check("done_cycle", cyc, e.cyc);
      end
    end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_start(input logic [63:0] t, input bit push, input int es, input bit ep, output int so);
    target = t;
    start  = 1'b1;
    so     = cyc + 1;
    if (push) begin
      sb.push_back('{es, ep, so + 81});
      n_exp++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [63:0] t, input int es, input bit ep);
    do_start(t, 1'b1, es, ep, s);
    check("busy_after_start", busy, 1);
    wait_to(s + 85);
    check("pending", sb.size(), 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_score", score, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_perfect", perfect, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check_reset_vals();
    run(ID_T, 64, 1);
    check("perfect_held", perfect, 1);
    run(INV_T, 0, 0);
    run(ID_T ^ (64'd1 << 37), 63, 0);
    run(64'd0, 32, 0);
    do_start(ID_T, 1'b1, 64, 1, s);
    wait_to(s + 20);
    target = INV_T;
    wait_to(s + 85);
    check("pending_tchg", sb.size(), 0);
    do_start(ID_T, 1'b1, 64, 1, s);
    for (int n = s; n <= s + 85; n++) begin
      wait_to(n);
      start = (n == s + 9 || n == s + 39);
      if ((n - s) % 5 == 2 && n - s < 80) check("dut_in_seq", dut_in, (n - s) / 5);
    end
    start = 1'b0;
    check("pending_multi", sb.size(), 0);
    do_start(ID_T, 1'b0, 0, 0, s);
    wait_to(s + 29);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_dut_in", dut_in, 0);
    check("abort_score", score, 20);
    check("abort_perfect", perfect, 0);
    wait_to(s + 95);
    run(ID_T, 64, 1);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 0);
    repeat (90) @(negedge clk);
    do_start(ID_T, 1'b0, 0, 0, s);
    wait_to(s + 49);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    repeat (90) @(negedge clk);
    run(ID_T, 64, 1);
    check("done_count", n_done, n_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
